// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: opcodes, default widths and small width helpers.
package tlul_pkg;

  // A-channel request opcodes
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  // D-channel response opcodes
  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // Default bus widths
  localparam int DEF_AW  = 32;
  localparam int DEF_DW  = 32;
  localparam int DEF_AIW = 8;
  localparam int DEF_DIW = 1;

  // Width of the a_size/d_size field for a given byte-lane count
  function automatic int calc_szw(input int dbw);
    return $clog2($clog2(dbw) + 1);
  endfunction

  // Width of a port index for np ports (never below one bit)
  function automatic int sel_w(input int np);
    return (np > 1) ? $clog2(np) : 1;
  endfunction

endpackage

// File: rtl/tlul_addr_decode.sv
// Combinational address decoder: lowest matching device wins, else the error port.
module tlul_addr_decode
  import tlul_pkg::*;
#(
  parameter int                     N_DEV     = 2,
  parameter int                     TL_AW     = 32,
  parameter int                     SELW      = sel_w(N_DEV + 1),
  parameter logic [N_DEV*TL_AW-1:0] ADDR_BASE = {32'h2000_0000, 32'h1000_0000},
  parameter logic [N_DEV*TL_AW-1:0] ADDR_MASK = {32'hF000_0000, 32'hF000_0000}
) (
  input  logic [TL_AW-1:0] addr,
  output logic [SELW-1:0]  sel
);

  logic [N_DEV-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < N_DEV; gi++) begin : g_match
      assign match[gi] = ((addr & ADDR_MASK[gi*TL_AW +: TL_AW]) == ADDR_BASE[gi*TL_AW +: TL_AW]);
    end
  endgenerate

  // Priority pick: scan from the top so the lowest matching index is kept
  always_comb begin
    sel = SELW'(N_DEV);
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (match[i]) sel = SELW'(i);
    end
  end

endmodule

// File: rtl/tlul_socket_1n.sv
// TL-UL 1:N socket: address-steered A channel, in-order D mux, outstanding tracking.
module tlul_socket_1n
  import tlul_pkg::*;
#(
  parameter int                     N_DEV     = 2,
  parameter int                     TL_AW     = DEF_AW,
  parameter int                     TL_DW     = DEF_DW,
  parameter int                     TL_AIW    = DEF_AIW,
  parameter int                     TL_DIW    = DEF_DIW,
  parameter int                     TL_DBW    = TL_DW >> 3,
  parameter int                     TL_SZW    = calc_szw(TL_DBW),
  parameter int                     MAX_OUT   = 4,
  parameter logic [N_DEV*TL_AW-1:0] ADDR_BASE = {32'h2000_0000, 32'h1000_0000},
  parameter logic [N_DEV*TL_AW-1:0] ADDR_MASK = {32'hF000_0000, 32'hF000_0000},
  localparam int                    NP        = N_DEV + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  // host A channel
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [2:0]            a_opcode,
  input  logic [2:0]            a_param,
  input  logic [TL_SZW-1:0]     a_size,
  input  logic [TL_AIW-1:0]     a_source,
  input  logic [TL_AW-1:0]      a_address,
  input  logic [TL_DBW-1:0]     a_mask,
  input  logic [TL_DW-1:0]      a_data,
  // host D channel
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [2:0]            d_opcode,
  output logic [2:0]            d_param,
  output logic [TL_SZW-1:0]     d_size,
  output logic [TL_AIW-1:0]     d_source,
  output logic [TL_DIW-1:0]     d_sink,
  output logic [TL_DW-1:0]      d_data,
  output logic                  d_error,
  // device A channels (payload broadcast)
  output logic [NP-1:0]         dev_a_valid,
  input  logic [NP-1:0]         dev_a_ready,
  output logic [2:0]            dev_a_opcode,
  output logic [2:0]            dev_a_param,
  output logic [TL_SZW-1:0]     dev_a_size,
  output logic [TL_AIW-1:0]     dev_a_source,
  output logic [TL_AW-1:0]      dev_a_address,
  output logic [TL_DBW-1:0]     dev_a_mask,
  output logic [TL_DW-1:0]      dev_a_data,
  // device D channels
  input  logic [NP-1:0]         dev_d_valid,
  output logic [NP-1:0]         dev_d_ready,
  input  logic [NP*3-1:0]       dev_d_opcode,
  input  logic [NP*3-1:0]       dev_d_param,
  input  logic [NP*TL_SZW-1:0]  dev_d_size,
  input  logic [NP*TL_AIW-1:0]  dev_d_source,
  input  logic [NP*TL_DIW-1:0]  dev_d_sink,
  input  logic [NP*TL_DW-1:0]   dev_d_data,
  input  logic [NP-1:0]         dev_d_error
);

  localparam int             SELW    = sel_w(NP);
  localparam int             CW      = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUT);

  logic [SELW-1:0] sel;
  logic [SELW-1:0] pend_sel_q, pend_sel_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [NP-1:0]   sel_hit, pend_hit;
  logic            cnt_empty, allow, a_ack, d_ack;

  tlul_addr_decode #(
    .N_DEV     (N_DEV),
    .TL_AW     (TL_AW),
    .SELW      (SELW),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_MASK (ADDR_MASK)
  ) u_decode (
    .addr (a_address),
    .sel  (sel)
  );

  // One-hot views of the decoded port and of the port owning outstanding traffic
  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_hit
      localparam logic [SELW-1:0] IDX = SELW'(gi);
      assign sel_hit[gi]  = (sel == IDX);
      assign pend_hit[gi] = (pend_sel_q == IDX);
    end
  endgenerate

  // Issue gate only looks at the address and state, never at device ready,
  // so no valid-from-ready combinational path exists.
  assign cnt_empty = (out_cnt_q == '0);
  assign allow     = (cnt_empty || (sel == pend_sel_q)) && (out_cnt_q < MAX_CNT);

  assign dev_a_valid = {NP{rstn & a_valid & allow}} & sel_hit;
  assign a_ready     = rstn & allow & (|(dev_a_ready & sel_hit));
  assign a_ack       = a_valid & a_ready;

  assign dev_a_opcode  = a_opcode;
  assign dev_a_param   = a_param;
  assign dev_a_size    = a_size;
  assign dev_a_source  = a_source;
  assign dev_a_address = a_address;
  assign dev_a_mask    = a_mask;
  assign dev_a_data    = a_data;

  // Responses are only taken from the owning port, and only while something is outstanding
  assign d_valid     = rstn & ~cnt_empty & (|(dev_d_valid & pend_hit));
  assign dev_d_ready = {NP{rstn & d_ready & ~cnt_empty}} & pend_hit;
  assign d_ack       = d_valid & d_ready;

  // D payload mux from the owning port
  always_comb begin
    d_opcode = '0;
    d_param  = '0;
    d_size   = '0;
    d_source = '0;
    d_sink   = '0;
    d_data   = '0;
    d_error  = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (pend_hit[i]) begin
        d_opcode = dev_d_opcode[i*3 +: 3];
        d_param  = dev_d_param[i*3 +: 3];
        d_size   = dev_d_size[i*TL_SZW +: TL_SZW];
        d_source = dev_d_source[i*TL_AIW +: TL_AIW];
        d_sink   = dev_d_sink[i*TL_DIW +: TL_DIW];
        d_data   = dev_d_data[i*TL_DW +: TL_DW];
        d_error  = dev_d_error[i];
      end
    end
  end

  // Next-state for the outstanding counter and owning port
  always_comb begin
    out_cnt_d  = out_cnt_q;
    pend_sel_d = pend_sel_q;
    if (a_ack) pend_sel_d = sel;
    case ({a_ack, d_ack})
      2'b10:   out_cnt_d = out_cnt_q + CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_cnt_q  <= '0;
      pend_sel_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      pend_sel_q <= pend_sel_d;
    end
  end

endmodule

// File: tb/tb_tlul_socket_1n.sv
// Self-checking bench for tlul_socket_1n: device responders plus an in-order scoreboard.
module tb_tlul_socket_1n;
  import tlul_pkg::*;

  localparam int NP = 3;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  src;
    logic [31:0] addr;
  } req_t;

  typedef struct {
    int          port;
    logic [2:0]  op;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic         clk;
  logic         rstn;
  logic         a_valid, a_ready;
  logic [2:0]   a_opcode, a_param;
  logic [1:0]   a_size;
  logic [7:0]   a_source;
  logic [31:0]  a_address;
  logic [3:0]   a_mask;
  logic [31:0]  a_data;
  logic         d_valid, d_ready;
  logic [2:0]   d_opcode, d_param;
  logic [1:0]   d_size;
  logic [7:0]   d_source;
  logic [0:0]   d_sink;
  logic [31:0]  d_data;
  logic         d_error;
  logic [NP-1:0]    dev_a_valid, dev_a_ready;
  logic [2:0]       dev_a_opcode, dev_a_param;
  logic [1:0]       dev_a_size;
  logic [7:0]       dev_a_source;
  logic [31:0]      dev_a_address;
  logic [3:0]       dev_a_mask;
  logic [31:0]      dev_a_data;
  logic [NP-1:0]    dev_d_valid, dev_d_ready;
  logic [NP*3-1:0]  dev_d_opcode, dev_d_param;
  logic [NP*2-1:0]  dev_d_size;
  logic [NP*8-1:0]  dev_d_source;
  logic [NP-1:0]    dev_d_sink;
  logic [NP*32-1:0] dev_d_data;
  logic [NP-1:0]    dev_d_error;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  req_t dq[NP][$];
  bit   pop_flag[NP];
  bit   resp_en[NP];
  bit   stray[NP];
  req_t rsp_head;

  tlul_socket_1n dut (
    .clk           (clk),
    .rstn          (rstn),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_opcode      (a_opcode),
    .a_param       (a_param),
    .a_size        (a_size),
    .a_source      (a_source),
    .a_address     (a_address),
    .a_mask        (a_mask),
    .a_data        (a_data),
    .d_valid       (d_valid),
    .d_ready       (d_ready),
    .d_opcode      (d_opcode),
    .d_param       (d_param),
    .d_size        (d_size),
    .d_source      (d_source),
    .d_sink        (d_sink),
    .d_data        (d_data),
    .d_error       (d_error),
    .dev_a_valid   (dev_a_valid),
    .dev_a_ready   (dev_a_ready),
    .dev_a_opcode  (dev_a_opcode),
    .dev_a_param   (dev_a_param),
    .dev_a_size    (dev_a_size),
    .dev_a_source  (dev_a_source),
    .dev_a_address (dev_a_address),
    .dev_a_mask    (dev_a_mask),
    .dev_a_data    (dev_a_data),
    .dev_d_valid   (dev_d_valid),
    .dev_d_ready   (dev_d_ready),
    .dev_d_opcode  (dev_d_opcode),
    .dev_d_param   (dev_d_param),
    .dev_d_size    (dev_d_size),
    .dev_d_source  (dev_d_source),
    .dev_d_sink    (dev_d_sink),
    .dev_d_data    (dev_d_data),
    .dev_d_error   (dev_d_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference address map: 0x1xxx_xxxx -> 0, 0x2xxx_xxxx -> 1, else error port
  function automatic int model_port(input logic [31:0] a);
    if ((a & 32'hF000_0000) == 32'h1000_0000) return 0;
    if ((a & 32'hF000_0000) == 32'h2000_0000) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] resp_data(input int p, input logic [31:0] a);
    logic [7:0] pb;
    pb = p[7:0];
    if (a == 32'h1000_0040) return 32'hDEAD_BEEF;
    return a ^ {pb, 24'h5A5A5A};
  endfunction

  // Monitor: sample handshakes on the falling edge, fill responders and scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < NP; i++) begin
        if (dev_a_valid[i] && dev_a_ready[i])
          dq[i].push_back('{op: dev_a_opcode, src: dev_a_source, addr: dev_a_address});
        if (dev_d_valid[i] && dev_d_ready[i]) pop_flag[i] = 1'b1;
      end
      if (a_valid && a_ready) begin
        int   p;
        exp_t e;
        p = model_port(a_address);
        check_eq("route", dev_a_valid, 64'(1) << p);
        e.port = p;
        e.op   = (a_opcode == Get) ? AccessAckData : AccessAck;
        e.src  = a_source;
        e.data = resp_data(p, a_address);
        e.err  = (p == 2);
        sb.push_back(e);
        $display("A  port=%0d op=%0h src=%02h addr=%08h", p, a_opcode, a_source, a_address);
      end
      if (d_valid && d_ready) begin
        check_eq("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("d_opcode", d_opcode, e.op);
          check_eq("d_source", d_source, e.src);
          check_eq("d_data", d_data, e.data);
          check_eq("d_error", d_error, e.err);
          check_eq("d_sink", d_sink, e.port[0]);
          check_eq("d_port", dev_d_ready, 64'(1) << e.port);
          $display("D  port=%0d op=%0h src=%02h data=%08h err=%0b", e.port, d_opcode, d_source, d_data, d_error);
        end
      end
    end
  end

  // Device responders: apply pops, then present the head of each port queue
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NP; i++) begin
      if (pop_flag[i]) begin
        if (dq[i].size() != 0) dq[i].delete(0);
        pop_flag[i] = 1'b0;
      end
      dev_d_param[i*3 +: 3] = 3'h0;
      dev_d_size[i*2 +: 2]  = 2'h2;
      dev_d_sink[i]         = i[0];
      dev_d_error[i]        = (i == 2);
      if (resp_en[i] && dq[i].size() != 0) begin
        rsp_head = dq[i][0];
        dev_d_valid[i]          = 1'b1;
        dev_d_opcode[i*3 +: 3]  = (rsp_head.op == Get) ? AccessAckData : AccessAck;
        dev_d_source[i*8 +: 8]  = rsp_head.src;
        dev_d_data[i*32 +: 32]  = resp_data(i, rsp_head.addr);
      end else begin
        dev_d_valid[i]          = stray[i];
        dev_d_opcode[i*3 +: 3]  = AccessAckData;
        dev_d_source[i*8 +: 8]  = 8'hEE;
        dev_d_data[i*32 +: 32]  = 32'hBAD0_0000;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] src);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_param   = 3'h0;
    a_size    = 2'h2;
    a_source  = src;
    a_address = addr;
    a_mask    = 4'hF;
    a_data    = addr ^ 32'h1234_5678;
  endtask

  // Issue one request and wait (bounded) for acceptance; called just after a rising edge
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] src);
    int waited;
    bit acc;
    waited = 0;
    acc    = 1'b0;
    drive_req(op, addr, src);
    while (!acc && waited < 20) begin
      @(negedge clk);
      if (a_ready) acc = 1'b1;
      step();
      waited++;
    end
    check_eq("send_accept", acc, 1);
    a_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check_eq("drain", sb.size(), 0);
  endtask

  initial begin
    rstn        = 1'b0;
    a_valid     = 1'b0;
    a_opcode    = 3'h0;
    a_param     = 3'h0;
    a_size      = 2'h0;
    a_source    = 8'h0;
    a_address   = 32'h0;
    a_mask      = 4'h0;
    a_data      = 32'h0;
    d_ready     = 1'b1;
    dev_a_ready = '1;
    dev_d_valid = '0;
    dev_d_opcode = '0; dev_d_param = '0; dev_d_size = '0; dev_d_source = '0;
    dev_d_sink  = '0; dev_d_data = '0; dev_d_error = '0;
    for (int i = 0; i < NP; i++) begin
      resp_en[i] = 1'b1; stray[i] = 1'b0; pop_flag[i] = 1'b0;
    end

    // Reset: outputs held low even with a request and a stray response present
    step();
    drive_req(Get, 32'h1000_0000, 8'h01);
    stray[0] = 1'b1;
    step();
    @(negedge clk);
    check_eq("rst_a_ready", a_ready, 0);
    check_eq("rst_dev_a_valid", dev_a_valid, 0);
    check_eq("rst_d_valid", d_valid, 0);
    check_eq("rst_dev_d_ready", dev_d_ready, 0);
    step();
    check_eq("rst_cnt", dut.out_cnt_q, 0);
    a_valid  = 1'b0;
    stray[0] = 1'b0;
    rstn     = 1'b1;
    step();

    // Routing to device 0 and its data response
    send(Get, 32'h1000_0040, 8'h12);
    wait_drain();

    // Unmapped address goes to the error responder
    send(PutFullData, 32'h5000_0000, 8'h33);
    wait_drain();

    // Device valid is raised regardless of that device's ready
    dev_a_ready[1] = 1'b0;
    drive_req(Get, 32'h2000_0010, 8'h21);
    @(negedge clk);
    check_eq("noready_valid", dev_a_valid, 3'b010);
    check_eq("noready_a_ready", a_ready, 0);
    step();
    dev_a_ready[1] = 1'b1;
    @(negedge clk);
    check_eq("ready_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    wait_drain();

    // Ordering stall: port 1 waits until port 0 drains
    resp_en[0] = 1'b0;
    send(Get, 32'h1000_0080, 8'h40);
    drive_req(Get, 32'h2000_0000, 8'h44);
    repeat (2) begin
      @(negedge clk);
      check_eq("stall_a_ready", a_ready, 0);
      check_eq("stall_dev_valid", dev_a_valid, 0);
      step();
    end
    resp_en[0] = 1'b1;
    @(negedge clk);
    check_eq("stall_at_dack", a_ready, 0);
    check_eq("stall_d_valid", d_valid, 1);
    step();
    @(negedge clk);
    check_eq("unstall_dev_valid", dev_a_valid, 3'b010);
    check_eq("unstall_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    wait_drain();

    // Full counter: four outstanding, fifth stalls, no same-cycle refill on d_ack
    resp_en[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(Get, 32'h1000_0100 + 32'(k * 4), 8'h50 + 8'(k));
    check_eq("full_cnt", dut.out_cnt_q, 4);
    drive_req(Get, 32'h1000_0200, 8'h55);
    repeat (2) begin
      @(negedge clk);
      check_eq("full_a_ready", a_ready, 0);
      check_eq("full_dev_valid", dev_a_valid, 0);
      step();
    end
    resp_en[0] = 1'b1;
    @(negedge clk);
    check_eq("full_no_refill", a_ready, 0);
    check_eq("full_d_valid", d_valid, 1);
    step();
    check_eq("full_dack_cnt", dut.out_cnt_q, 3);
    @(negedge clk);
    check_eq("refill_a_ready", a_ready, 1);
    check_eq("refill_d_valid", d_valid, 1);
    step();
    a_valid = 1'b0;
    check_eq("both_ack_cnt", dut.out_cnt_q, 3);
    wait_drain();

    // Stray response with nothing outstanding is neither forwarded nor acked
    stray[1] = 1'b1;
    step();
    @(negedge clk);
    check_eq("stray_d_valid", d_valid, 0);
    check_eq("stray_dev_d_ready", dev_d_ready, 0);
    step();
    stray[1] = 1'b0;

    // Reset in the middle of two outstanding requests
    resp_en[0] = 1'b0;
    send(Get, 32'h1000_0300, 8'h60);
    send(Get, 32'h1000_0304, 8'h61);
    check_eq("mid_cnt", dut.out_cnt_q, 2);
    drive_req(Get, 32'h2000_0020, 8'h77);
    resp_en[0] = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    check_eq("midrst_a_ready", a_ready, 0);
    check_eq("midrst_dev_a_valid", dev_a_valid, 0);
    check_eq("midrst_d_valid", d_valid, 0);
    check_eq("midrst_dev_d_ready", dev_d_ready, 0);
    step();
    rstn = 1'b1;
    resp_en[0] = 1'b0;
    sb.delete();
    for (int i = 0; i < NP; i++) dq[i].delete();
    check_eq("midrst_cnt", dut.out_cnt_q, 0);
    @(negedge clk);
    check_eq("postrst_a_ready", a_ready, 1);
    check_eq("postrst_dev_valid", dev_a_valid, 3'b010);
    step();
    a_valid = 1'b0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
